// File: rtl/i2c_word_fifo.sv
// 32-bit first-word-fall-through FIFO on the i2c_phy data path.
// Used twice: RX (phy pushes, CPU pops) and TX (CPU pushes, phy pops).
//
// Handshake: a write is taken on a rising edge when wr_en=1 and either the
// FIFO is not full or a read is taken in the same edge. A read is taken when
// rd_en=1 and empty=0. rd_data holds the head word whenever empty=0, so the
// consumer may sample it in the same cycle it raises rd_en. Requests that
// cannot be taken are dropped and flagged by a one-cycle overflow/underflow
// pulse. flush overrides both strobes.
module i2c_word_fifo #(
  parameter int WIDTH     = 32,
  parameter int AW        = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_LVL);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count_q;
  logic             full_w;
  logic             empty_w;
  logic             wr_acc;
  logic             rd_acc;
  logic             ovf_q;
  logic             unf_q;

  // The extra pointer MSB distinguishes full from empty when low bits match.
  assign empty_w = (wr_ptr == rd_ptr);
  assign full_w  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A read on a full FIFO frees a slot, so the paired write still fits.
  // A read on an empty FIFO is never bypassed by a same-cycle write.
  assign wr_acc = !flush && wr_en && (!full_w || rd_en);
  assign rd_acc = !flush && rd_en && !empty_w;

  assign full        = full_w;
  assign empty       = empty_w;
  assign count       = count_q;
  assign almost_full = (count_q >= AFULL_C);
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign rd_data     = empty_w ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer and occupancy registers; flush clears them synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because empty masks rd_data.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // One-cycle error pulses for dropped requests; flush suppresses both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= !flush && wr_en && full_w && !rd_en;
      unf_q <= !flush && rd_en && empty_w;
    end
  end

endmodule

// File: tb/tb_i2c_word_fifo.sv
// Self-checking bench for i2c_word_fifo: directed scenarios plus a random
// interleave, all checked against a queue-based reference model.
module tb_i2c_word_fifo;

  localparam int W = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AFL = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_en = 1'b0;
  logic          full, almost_full, empty, overflow, underflow;
  logic [W-1:0]  rd_data;
  logic [AW:0]   count;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  logic         exp_ovf = 1'b0;
  logic         exp_unf = 1'b0;

  i2c_word_fifo #(.WIDTH(W), .AW(AW), .AFULL_LVL(AFL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  // Driver: apply one cycle of stimulus, advance the model, return at posedge+1
  task automatic drive(input logic we, input logic [W-1:0] wd, input logic re, input logic fl);
    int sz;
    sz = exp_q.size();
    wr_en = we; wr_data = wd; rd_en = re; flush = fl;
    if (fl) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      exp_ovf = we && (sz == DEPTH) && !re;
      exp_unf = re && (sz == 0);
      if (re && sz != 0) void'(exp_q.pop_front());
      if (we && (sz != DEPTH || re)) exp_q.push_back(wd);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    exp_q.delete();
    #12;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if ({full, almost_full, overflow, underflow} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {full, almost_full, overflow, underflow}); end
    n_cmp++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] words[3];
    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
    drive(1'b1, words[0], 1'b0, 1'b0);
    n_cmp++; if (rd_data !== words[0] || empty !== 1'b0) begin n_fail++; $display("FAIL basic_first_word: got %h empty=%b want %h empty=0", rd_data, empty, words[0]); end
    drive(1'b1, words[1], 1'b0, 1'b0);
    drive(1'b1, words[2], 1'b0, 1'b0);
    n_cmp++; if (count !== 5'd3) begin n_fail++; $display("FAIL basic_count3: got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rd_data !== words[i]) begin n_fail++; $display("FAIL basic_read%0d: got %h want %h", i, rd_data, words[i]); end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    n_cmp++; if (empty !== 1'b1 || count !== '0) begin n_fail++; $display("FAIL basic_drained: got empty=%b count=%0d want 1/0", empty, count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b0);
      n_cmp++; if (almost_full !== (i + 1 >= AFL)) begin n_fail++; $display("FAIL fill_afull@%0d: got %b want %b", i + 1, almost_full, (i + 1 >= AFL)); end
      n_cmp++; if (full !== (i + 1 == DEPTH)) begin n_fail++; $display("FAIL fill_full@%0d: got %b want %b", i + 1, full, (i + 1 == DEPTH)); end
    end
    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    n_cmp++; if (overflow !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL fill_overflow: got ovf=%b count=%0d want 1/16", overflow, count); end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_pulse: got %b want 0", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (rd_data !== W'(i)) begin n_fail++; $display("FAIL fill_readback%0d: got %h want %h", i, rd_data, W'(i)); end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_drained: got empty=%b want 1", empty); end
  endtask

  task automatic test_full_rw();
    logic [W-1:0] got;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, W'(i), 1'b0, 1'b0);
    drive(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
    n_cmp++; if (count !== 5'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL fullrw_count: got count=%0d ovf=%b want 16/0", count, overflow); end
    n_cmp++; if (rd_data !== 32'h1) begin n_fail++; $display("FAIL fullrw_head: got %h want 00000001", rd_data); end
    got = '0;
    while (exp_q.size() != 0) begin
      n_cmp++; if (rd_data !== exp_head()) begin n_fail++; $display("FAIL fullrw_drain: got %h want %h", rd_data, exp_head()); end
      got = rd_data;
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    n_cmp++; if (got !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL fullrw_last: got %h want a5a5a5a5", got); end
  endtask

  task automatic test_empty_rw();
    drive(1'b1, 32'h12345678, 1'b1, 1'b0);
    n_cmp++; if (underflow !== 1'b1 || count !== 5'd1) begin n_fail++; $display("FAIL emptyrw_unf: got unf=%b count=%0d want 1/1", underflow, count); end
    n_cmp++; if (rd_data !== 32'h12345678) begin n_fail++; $display("FAIL emptyrw_data: got %h want 12345678", rd_data); end
    drive(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (underflow !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL emptyrw_after: got unf=%b empty=%b want 0/1", underflow, empty); end
  endtask

  task automatic test_random();
    logic [W-1:0] pat;
    logic we, re;
    pat = 32'h100;
    for (int i = 0; i < 300; i++) begin
      we = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < 45);
      drive(we, pat, re, 1'b0);
      if (we) pat = pat + 1;
      n_cmp++; if (count !== (AW+1)'(exp_q.size()) || count > 5'd16) begin n_fail++; $display("FAIL rand_count@%0d: got %0d want %0d", i, count, exp_q.size()); end
      n_cmp++; if (rd_data !== exp_head()) begin n_fail++; $display("FAIL rand_data@%0d: got %h want %h", i, rd_data, exp_head()); end
      n_cmp++; if ({empty, full, almost_full} !== {exp_q.size() == 0, exp_q.size() == DEPTH, exp_q.size() >= AFL}) begin n_fail++; $display("FAIL rand_flags@%0d: got %b want %b", i, {empty, full, almost_full}, {exp_q.size() == 0, exp_q.size() == DEPTH, exp_q.size() >= AFL}); end
      n_cmp++; if ({overflow, underflow} !== {exp_ovf, exp_unf}) begin n_fail++; $display("FAIL rand_pulses@%0d: got %b want %b", i, {overflow, underflow}, {exp_ovf, exp_unf}); end
    end
    while (exp_q.size() != 0) begin
      n_cmp++; if (rd_data !== exp_head()) begin n_fail++; $display("FAIL rand_drain: got %h want %h", rd_data, exp_head()); end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    drive(1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    n_cmp++; if (count !== '0 || empty !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL flush: got count=%0d empty=%b ovf=%b want 0/1/0", count, empty, overflow); end
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hBEEF0000 + W'(i), 1'b0, 1'b0);
    n_cmp++; if (count !== 5'd3) begin n_fail++; $display("FAIL prereset_count: got %0d want 3", count); end
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++; if (empty !== 1'b1 || count !== '0 || rd_data !== '0) begin n_fail++; $display("FAIL async_reset: got empty=%b count=%0d data=%h want 1/0/0", empty, count, rd_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (empty !== 1'b1 || count !== '0) begin n_fail++; $display("FAIL post_reset: got empty=%b count=%0d want 1/0", empty, count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_rw();
    test_empty_rw();
    test_random();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_word_fifo.md
Name: i2c_word_fifo

Overview:
- 32-bit first-word-fall-through (FWFT) synchronous FIFO on the i2c_phy data path.
- Two instances:
  - RX: i2c_phy push/dout -> fifo write side; CPU/wishbone pops.
  - TX: CPU pushes; fifo read side -> i2c_phy pop/din.
- FWFT is mandatory on the read side: i2c_phy loads din in the same cycle pop is high, so rd_data is valid whenever empty=0.

Parameters:
- WIDTH, 32, data word width in bits.
- AW, 4, address width; DEPTH = 2**AW words (16).
- AFULL_LVL, 12, almost_full asserts when count >= AFULL_LVL; legal range 1..DEPTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear; empties the FIFO.
- wr_en  in  1  write strobe (i2c_phy push / CPU write).
- wr_data  in  WIDTH  write data (i2c_phy dout / CPU data).
- full  out  1  count == DEPTH (drives i2c_phy full).
- almost_full  out  1  count >= AFULL_LVL.
- rd_en  in  1  read strobe (i2c_phy pop / CPU read).
- rd_data  out  WIDTH  head word; valid when empty=0 (drives i2c_phy din).
- empty  out  1  count == 0 (drives i2c_phy empty).
- count  out  AW+1  number of stored words, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write dropped.
- underflow  out  1  one-cycle pulse: read ignored.

Behaviour:
- Reset, async on rst_n low:
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1; full = almost_full = overflow = underflow = 0.
  - rd_data = 0; memory contents are don't-care.
- Pointers and storage:
  - Pointers are AW+1 bits, with the MSB used as wrap bit.
  - full = (ptr low bits equal) and (MSBs differ); empty = (ptrs equal).
  - Increments wrap naturally modulo 2**(AW+1).
  - Storage is a register array; rd_data = mem[rd_ptr[AW-1:0]] combinationally, with 0 output when empty.
- Write accept = wr_en && (!full || rd_en).
  - When full, a simultaneous read frees a slot, so the write is accepted.
- Read accept = rd_en && !empty.
  - When empty, a simultaneous write is NOT bypassed: the read is ignored and the write is stored.
- Count update:
  - count is registered: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
  - All flags update the cycle after the accepting edge.
- Latency:
  - Word written at edge N is visible on rd_data with empty=0 after edge N (zero extra pipeline).
- Overflow / underflow:
  - overflow = 1 for one cycle after an edge where wr_en && full && !rd_en.
    - The data is dropped and no pointer moves.
  - underflow = 1 for one cycle after an edge where rd_en && empty.
    - No pointer moves.
- flush:
  - Sets wr_ptr = rd_ptr = count = 0 on the next edge.
  - Takes priority over wr_en and rd_en in the same cycle; neither is accepted and no overflow/underflow pulse is produced.
- Reset mid-operation:
  - All contents are lost immediately on rst_n low.
  - Outputs hold their reset values until the first edge after rst_n rises.
- Data integrity:
  - Order is strictly FIFO.
  - rd_data changes only on an accepted read, an accepted write into an empty FIFO, flush, or reset.
- Pulse rates: producers may assert wr_en/rd_en on consecutive cycles; i2c_phy push/pop are single-cycle pulses.

Test Plan:
- Reset, then write 0x11111111, 0x22222222, 0x33333333 on 3 consecutive cycles -> count=3, empty=0, rd_data=0x11111111 on the cycle after the first write; three rd_en pulses return 0x11111111, 0x22222222, 0x33333333, then empty=1, count=0.
- Fill 16 words 0x00000000..0x0000000F -> almost_full=1 from count 12, full=1 at 16; 17th write 0xDEADBEEF -> overflow pulse for 1 cycle, count stays 16, readback 0x0..0xF with no 0xDEADBEEF.
- With FIFO full, assert wr_en (0xA5A5A5A5) and rd_en together -> count stays 16, no overflow, head advances to 0x00000001, and 0xA5A5A5A5 is read last.
- Empty FIFO, assert rd_en and wr_en (0x12345678) together -> underflow pulse, count=1, rd_data=0x12345678.
- Run 40 writes/reads interleaved (ptr wrap 2x) with an incrementing pattern -> every word is read in order, and count never exceeds 16.
- Load 5 words, assert flush together with wr_en -> count=0, empty=1, no overflow; then assert rst_n low mid-stream with 3 words stored -> empty=1, count=0, rd_data=0 immediately.
